// File: rtl/strip_alloc_update.sv
// strip_alloc_update: keeps the per-strip occupied-width table. Each accepted
// request is re-checked against the table. If the rectangle fits, the new
// width is committed and the placement X is reported. Three combinational
// read ports drive the upstream least-width selector.
module strip_alloc_update #(
   parameter int MAX_WIDTH  = 128,
   parameter int NUM_STRIPS = 13
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  clear_i,
   input  logic                  valid_i,
   output logic                  ready_o,
   input  logic [3:0]            strip_id_i,
   input  logic [7:0]            strip_width_i,
   input  logic [7:0]            rect_width_i,
   output logic                  place_valid_o,
   output logic                  place_ok_o,
   output logic                  place_stale_o,
   output logic [3:0]            place_strip_id_o,
   output logic [7:0]            place_x_o,
   output logic [7:0]            placed_count_o,
   output logic [NUM_STRIPS-1:0] full_mask_o,
   input  logic [3:0]            rd_id_0_i,
   input  logic [3:0]            rd_id_1_i,
   input  logic [3:0]            rd_id_2_i,
   output logic [7:0]            rd_width_0_o,
   output logic [7:0]            rd_width_1_o,
   output logic [7:0]            rd_width_2_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CHECK = 2'd1,
      RESP  = 2'd2
   } state_t;

   localparam logic [7:0] FULL_W8 = 8'(MAX_WIDTH);
   localparam logic [8:0] FULL_W9 = 9'(MAX_WIDTH);
   localparam logic [4:0] NUM_S5  = 5'(NUM_STRIPS);

   state_t state_reg, state_next;
   logic   ready;
   logic   accept;

   // Request fields captured at the acceptance edge.
   logic [3:0] id_reg;
   logic [7:0] hint_reg;
   logic [7:0] rect_reg;

   // The width table. Flops rather than block RAM, because three
   // combinational read ports and one check port are needed at once.
   logic [7:0] table_reg [NUM_STRIPS];

   logic                  place_valid_reg;
   logic                  place_ok_reg;
   logic                  place_stale_reg;
   logic [3:0]            place_id_reg;
   logic [7:0]            place_x_reg;
   logic [7:0]            count_reg;
   logic [NUM_STRIPS-1:0] full_mask_reg;

   // Check datapath signals.
   logic       in_range;
   logic [7:0] old_width;
   logic [8:0] sum;
   logic       fit;
   logic       commit;

   // Table lookup. An ID with no strip behind it reads as a full strip,
   // so the selector never picks a strip that does not exist.
   function automatic logic [7:0] table_read(input logic [3:0] id);
      logic [7:0] val;
      val = FULL_W8;
      for (int k = 0; k < NUM_STRIPS; k++) begin
         if (id == 4'(k)) begin
            val = table_reg[k];
         end
      end
      return val;
   endfunction

   // Next-state and handshake decode.
   always_comb begin
      state_next = state_reg;
      ready      = 1'b1;
      case (state_reg)
         IDLE: begin
            if (valid_i) state_next = CHECK;
         end
         CHECK: begin
            ready      = 1'b0;
            state_next = RESP;
         end
         RESP: begin
            if (valid_i) state_next = CHECK;
            else         state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign accept = valid_i & ready & ~clear_i;

   // State register. A clear forces IDLE, which drops any request in CHECK.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_reg <= IDLE;
      end else if (clear_i) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Capture the request fields when a request is accepted.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         id_reg   <= 4'd0;
         hint_reg <= 8'd0;
         rect_reg <= 8'd0;
      end else if (accept) begin
         id_reg   <= strip_id_i;
         hint_reg <= strip_width_i;
         rect_reg <= rect_width_i;
      end
   end

   // Fit check against the authoritative table. The sum is 9 bits wide so
   // that it cannot wrap.
   always_comb begin
      in_range  = ({1'b0, id_reg} < NUM_S5);
      old_width = table_read(id_reg);
      sum       = {1'b0, old_width} + {1'b0, rect_reg};
      fit       = in_range & (rect_reg != 8'd0) & (sum <= FULL_W9);
      commit    = (state_reg == CHECK) & fit & ~clear_i;
   end

   // Table and full-mask update. Both change on the same edge, so the mask
   // always matches the table.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int k = 0; k < NUM_STRIPS; k++) table_reg[k] <= 8'd0;
         full_mask_reg <= '0;
      end else if (clear_i) begin
         for (int k = 0; k < NUM_STRIPS; k++) table_reg[k] <= 8'd0;
         full_mask_reg <= '0;
      end else if (commit) begin
         for (int k = 0; k < NUM_STRIPS; k++) begin
            if (id_reg == 4'(k)) begin
               table_reg[k]     <= sum[7:0];
               full_mask_reg[k] <= (sum == FULL_W9);
            end
         end
      end
   end

   // Count successful placements. The count saturates at 255.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count_reg <= 8'd0;
      end else if (clear_i) begin
         count_reg <= 8'd0;
      end else if (commit && count_reg != 8'hFF) begin
         count_reg <= count_reg + 8'd1;
      end
   end

   // Result registers. The valid bit pulses for the RESP cycle only.
   // The other fields hold until the next result.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         place_valid_reg <= 1'b0;
         place_ok_reg    <= 1'b0;
         place_stale_reg <= 1'b0;
         place_id_reg    <= 4'd0;
         place_x_reg     <= 8'd0;
      end else if (clear_i) begin
         place_valid_reg <= 1'b0;
      end else if (state_reg == CHECK) begin
         place_valid_reg <= 1'b1;
         place_ok_reg    <= fit;
         place_stale_reg <= in_range & (old_width != hint_reg);
         place_id_reg    <= id_reg;
         place_x_reg     <= in_range ? old_width : 8'd0;
      end else begin
         place_valid_reg <= 1'b0;
      end
   end

   assign ready_o          = ready;
   assign place_valid_o    = place_valid_reg;
   assign place_ok_o       = place_ok_reg;
   assign place_stale_o    = place_stale_reg;
   assign place_strip_id_o = place_id_reg;
   assign place_x_o        = place_x_reg;
   assign placed_count_o   = count_reg;
   assign full_mask_o      = full_mask_reg;

   assign rd_width_0_o = table_read(rd_id_0_i);
   assign rd_width_1_o = table_read(rd_id_1_i);
   assign rd_width_2_o = table_read(rd_id_2_i);

endmodule

// File: tb/tb_strip_alloc_update.sv
// tb_strip_alloc_update: directed steps against hand-computed expected values.
module tb_strip_alloc_update;

   logic        clk;
   logic        rst;
   logic        clear;
   logic        valid;
   logic        ready;
   logic [3:0]  strip_id;
   logic [7:0]  strip_width;
   logic [7:0]  rect_width;
   logic        place_valid;
   logic        place_ok;
   logic        place_stale;
   logic [3:0]  place_strip_id;
   logic [7:0]  place_x;
   logic [7:0]  placed_count;
   logic [12:0] full_mask;
   logic [3:0]  rd_id_0, rd_id_1, rd_id_2;
   logic [7:0]  rd_width_0, rd_width_1, rd_width_2;

   int checks   = 0;
   int failures = 0;

   strip_alloc_update #(.MAX_WIDTH(128), .NUM_STRIPS(13)) dut (
      .clk_i(clk),
      .rst_i(rst),
      .clear_i(clear),
      .valid_i(valid),
      .ready_o(ready),
      .strip_id_i(strip_id),
      .strip_width_i(strip_width),
      .rect_width_i(rect_width),
      .place_valid_o(place_valid),
      .place_ok_o(place_ok),
      .place_stale_o(place_stale),
      .place_strip_id_o(place_strip_id),
      .place_x_o(place_x),
      .placed_count_o(placed_count),
      .full_mask_o(full_mask),
      .rd_id_0_i(rd_id_0),
      .rd_id_1_i(rd_id_1),
      .rd_id_2_i(rd_id_2),
      .rd_width_0_o(rd_width_0),
      .rd_width_1_o(rd_width_1),
      .rd_width_2_o(rd_width_2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; sample 1 ns after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one request and return 1 ns after the result edge (RESP cycle).
   task automatic req(input logic [3:0] id, input logic [7:0] hint, input logic [7:0] rect);
      valid       = 1'b1;
      strip_id    = id;
      strip_width = hint;
      rect_width  = rect;
      tick();
      valid = 1'b0;
      tick();
      $display("req id=%0d hint=%0d rect=%0d -> pv=%0b ok=%0b x=%0d stale=%0b cnt=%0d",
               id, hint, rect, place_valid, place_ok, place_x, place_stale, placed_count);
   endtask

   initial begin
      rst = 1'b1; clear = 1'b0; valid = 1'b0;
      strip_id = 4'd0; strip_width = 8'd0; rect_width = 8'd0;
      rd_id_0 = 4'd3; rd_id_1 = 4'd5; rd_id_2 = 4'd2;
      #12;
      rst = 1'b0;
      tick();
      check("rst_ready", ready, 1);
      check("rst_pvalid", place_valid, 0);
      check("rst_count", placed_count, 0);
      check("rst_mask", full_mask, 0);
      check("rst_rd3", rd_width_0, 0);
      check("rst_x", place_x, 0);

      // First placement with reset latency checks.
      valid = 1'b1; strip_id = 4'd3; strip_width = 8'd0; rect_width = 8'd40;
      tick();
      valid = 1'b0;
      check("e0_ready", ready, 0);
      check("e0_pvalid", place_valid, 0);
      tick();
      $display("req id=3 hint=0 rect=40 -> pv=%0b ok=%0b x=%0d", place_valid, place_ok, place_x);
      check("p1_valid", place_valid, 1);
      check("p1_ok", place_ok, 1);
      check("p1_x", place_x, 0);
      check("p1_stale", place_stale, 0);
      check("p1_id", place_strip_id, 3);
      check("p1_rd3", rd_width_0, 40);
      check("p1_count", placed_count, 1);
      check("p1_ready", ready, 1);
      tick();
      check("p1_pulse_end", place_valid, 0);

      // Clear, then back-to-back requests on strip 3.
      clear = 1'b1; tick(); clear = 1'b0;
      check("clr_rd3", rd_width_0, 0);
      check("clr_count", placed_count, 0);
      valid = 1'b1; strip_id = 4'd3; strip_width = 8'd0; rect_width = 8'd40;
      tick();
      strip_width = 8'd40; rect_width = 8'd48;   // stays valid, so it is accepted in RESP
      tick();
      check("b2b1_valid", place_valid, 1);
      check("b2b1_x", place_x, 0);
      check("b2b1_ready", ready, 1);
      tick();
      valid = 1'b0;
      check("b2b_check_ready", ready, 0);
      check("b2b_check_pv", place_valid, 0);
      tick();
      $display("b2b second -> pv=%0b ok=%0b x=%0d rd3=%0d cnt=%0d", place_valid, place_ok, place_x, rd_width_0, placed_count);
      check("b2b2_valid", place_valid, 1);
      check("b2b2_ok", place_ok, 1);
      check("b2b2_x", place_x, 40);
      check("b2b2_stale", place_stale, 0);
      check("b2b2_rd3", rd_width_0, 88);
      check("b2b2_count", placed_count, 2);

      // Fill strip 5 exactly, then reject an overflow.
      req(4'd5, 8'd0, 8'd100);
      check("s5a_ok", place_ok, 1);
      req(4'd5, 8'd100, 8'd28);
      check("s5b_ok", place_ok, 1);
      check("s5b_x", place_x, 100);
      check("s5b_rd5", rd_width_1, 128);
      check("s5b_mask", full_mask, 13'h0020);
      check("s5b_count", placed_count, 4);
      req(4'd5, 8'd128, 8'd1);
      check("s5c_valid", place_valid, 1);
      check("s5c_ok", place_ok, 0);
      check("s5c_rd5", rd_width_1, 128);
      check("s5c_count", placed_count, 4);

      // A stale hint is flagged, but the placement still commits.
      req(4'd2, 8'd0, 8'd10);
      req(4'd2, 8'd0, 8'd5);
      check("st_ok", place_ok, 1);
      check("st_x", place_x, 10);
      check("st_stale", place_stale, 1);
      check("st_rd2", rd_width_2, 15);
      check("st_count", placed_count, 6);

      // Out-of-range ID and zero-width rectangle.
      req(4'd14, 8'd0, 8'd5);
      check("oor_ok", place_ok, 0);
      check("oor_x", place_x, 0);
      check("oor_stale", place_stale, 0);
      check("oor_id", place_strip_id, 14);
      req(4'd1, 8'd0, 8'd0);
      check("zero_ok", place_ok, 0);
      check("zero_x", place_x, 0);
      check("zero_count", placed_count, 6);

      // Read ports for IDs beyond the table report a full strip.
      rd_id_0 = 4'd15; rd_id_1 = 4'd13; #1;
      check("rd15", rd_width_0, 128);
      check("rd13", rd_width_1, 128);
      rd_id_0 = 4'd3; rd_id_1 = 4'd5; #1;

      // A sum of MAX_WIDTH+1 is rejected; exactly MAX_WIDTH is accepted.
      req(4'd3, 8'd88, 8'd41);
      check("b129_ok", place_ok, 0);
      check("b129_rd3", rd_width_0, 88);
      req(4'd3, 8'd88, 8'd40);
      check("b128_ok", place_ok, 1);
      check("b128_mask", full_mask, 13'h0028);
      check("b128_count", placed_count, 7);
      tick();

      // A valid request in the same cycle as clear is not accepted.
      clear = 1'b1; valid = 1'b1; strip_id = 4'd0; rect_width = 8'd10;
      tick();
      clear = 1'b0; valid = 1'b0;
      check("clrv_ready", ready, 1);
      check("clrv_mask", full_mask, 0);
      tick();
      check("clrv_pvalid", place_valid, 0);

      // A clear during CHECK drops the request without a pulse.
      req(4'd0, 8'd0, 8'd10);
      check("pre_clr_count", placed_count, 1);
      tick();
      valid = 1'b1; strip_id = 4'd4; strip_width = 8'd0; rect_width = 8'd20;
      tick();
      valid = 1'b0; clear = 1'b1;
      tick();
      clear = 1'b0;
      $display("clear in CHECK -> pv=%0b ready=%0b cnt=%0d", place_valid, ready, placed_count);
      check("clrc_pvalid", place_valid, 0);
      check("clrc_ready", ready, 1);
      check("clrc_count", placed_count, 0);
      check("clrc_rd3", rd_width_0, 0);
      check("clrc_rd5", rd_width_1, 0);
      check("clrc_mask", full_mask, 0);
      tick();
      check("clrc_pvalid2", place_valid, 0);

      // An asynchronous reset during CHECK takes effect immediately.
      req(4'd6, 8'd0, 8'd30);
      tick();
      valid = 1'b1; strip_id = 4'd2; strip_width = 8'd0; rect_width = 8'd7;
      tick();
      valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      $display("async reset in CHECK -> pv=%0b ready=%0b cnt=%0d", place_valid, ready, placed_count);
      check("arst_count", placed_count, 0);
      check("arst_ready", ready, 1);
      check("arst_pvalid", place_valid, 0);
      check("arst_ok", place_ok, 0);
      check("arst_x", place_x, 0);
      check("arst_id", place_strip_id, 0);
      check("arst_rd2", rd_width_2, 0);
      check("arst_mask", full_mask, 0);
      #1 rst = 1'b0;
      tick();
      check("arst_pvalid2", place_valid, 0);
      check("arst_rd2b", rd_width_2, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
